// File: rtl/definitions.sv
// Shared definitions for the program loader.
//   INST_MEM_SIZE     default instruction word width in bits
//   INST_MEM_DEPTH    default instruction memory address width
//   loader_state_type loader FSM state encoding
package definitions;

    localparam int unsigned INST_MEM_SIZE  = 32;
    localparam int unsigned INST_MEM_DEPTH = 10;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECK,
        ERROR
    } loader_state_type;

endpackage

// File: rtl/chunk_assembler.sv
// Shifts IN_WIDTH chunks little-endian into a WORD_WIDTH word.
//   clk, reset   clock and synchronous active-high reset
//   clear        restart word assembly (drops any partial word)
//   chunk_valid  chunk_data is consumed this cycle
//   chunk_data   incoming chunk
//   word         assembled word including the current chunk
//   word_valid   word is complete this cycle (last chunk consumed)
module chunk_assembler #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  chunk_valid,
    input  logic [IN_WIDTH-1:0]   chunk_data,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int unsigned CHUNKS = WORD_WIDTH / IN_WIDTH;
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;

    // New chunk enters at the top so the first chunk ends up in the low bits.
    assign word = (shift_q >> IN_WIDTH) | (WORD_WIDTH'(chunk_data) << (WORD_WIDTH - IN_WIDTH));

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (chunk_valid) begin
            shift_d    = word;
            word_valid = (cnt_q == LAST);
            cnt_d      = word_valid ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a framed program image (header word count, instruction words, XOR checksum) from a
// host chunk stream into instruction memory, and holds the Controller in reset until a
// complete, checksum-valid image has been written.
//   clk, reset         clock and synchronous active-high reset
//   start              begin a load (honoured in IDLE or ERROR only)
//   in_data/in_valid   host stream; transfer = in_valid && in_ready
//   in_ready           loader accepts a chunk (registered, depends on state only)
//   inst_write_*       single-cycle instruction memory write port
//   controller_hold    keep the Controller in reset while high
//   busy               HEADER, PAYLOAD or CHECK
//   done               one-cycle pulse on a successful load
//   error              sticky load failure, cleared by start
module program_loader #(
    parameter int unsigned INST_MEM_SIZE  = definitions::INST_MEM_SIZE,
    parameter int unsigned INST_MEM_DEPTH = definitions::INST_MEM_DEPTH,
    parameter int unsigned IN_WIDTH       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [INST_MEM_DEPTH-1:0] inst_write_addr,
    output logic [INST_MEM_SIZE-1:0]  inst_write_data,
    output logic                      inst_write_enable,
    output logic                      controller_hold,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    import definitions::*;

    // Word counts run 1..2^INST_MEM_DEPTH, so they need one bit more than an address.
    localparam int unsigned CNT_W = INST_MEM_DEPTH + 1;
    localparam logic [INST_MEM_SIZE-1:0] MAX_COUNT = INST_MEM_SIZE'(1) << INST_MEM_DEPTH;

    loader_state_type          state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic [INST_MEM_DEPTH-1:0] addr_q, addr_d;
    logic [IN_WIDTH-1:0]       csum_q, csum_d;
    logic [INST_MEM_DEPTH-1:0] waddr_q, waddr_d;
    logic [INST_MEM_SIZE-1:0]  wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic                      hold_q, hold_d;
    logic                      done_q, done_d;
    logic                      in_ready_q;
    logic                      error_q;

    logic                      xfer;
    logic                      asm_clear;
    logic                      asm_valid;
    logic [INST_MEM_SIZE-1:0]  asm_word;
    logic                      word_valid;

    assign xfer = in_valid && in_ready_q;

    chunk_assembler #(
        .WORD_WIDTH (INST_MEM_SIZE),
        .IN_WIDTH   (IN_WIDTH)
    ) u_chunk_assembler (
        .clk         (clk),
        .reset       (reset),
        .clear       (asm_clear),
        .chunk_valid (asm_valid),
        .chunk_data  (in_data),
        .word        (asm_word),
        .word_valid  (word_valid)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        csum_d     = csum_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        hold_d     = hold_q;
        done_d     = 1'b0;
        asm_clear  = 1'b0;
        asm_valid  = 1'b0;
        unique case (state_q)
            IDLE, ERROR: begin
                if (start) begin
                    state_d    = HEADER;
                    asm_clear  = 1'b1;
                    count_d    = '0;
                    word_cnt_d = '0;
                    addr_d     = '0;
                    csum_d     = '0;
                    hold_d     = 1'b1;
                end
            end
            HEADER: begin
                asm_valid = xfer;
                if (word_valid) begin
                    if (asm_word != '0 && asm_word <= MAX_COUNT) begin
                        count_d = asm_word[CNT_W-1:0];
                        state_d = PAYLOAD;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            PAYLOAD: begin
                asm_valid = xfer;
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                end
                if (word_valid) begin
                    we_d       = 1'b1;
                    waddr_d    = addr_q;
                    wdata_d    = asm_word;
                    // Wraps to 0 after the all-ones address; no write follows the wrap.
                    addr_d     = addr_q + INST_MEM_DEPTH'(1);
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (word_cnt_d == count_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            csum_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            csum_q     <= csum_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            in_ready_q <= (state_d == HEADER) || (state_d == PAYLOAD) || (state_d == CHECK);
            error_q    <= (state_d == ERROR);
        end
    end

    assign in_ready          = in_ready_q;
    assign inst_write_addr   = waddr_q;
    assign inst_write_data   = wdata_q;
    assign inst_write_enable = we_q;
    assign controller_hold   = hold_q;
    assign busy              = (state_q == HEADER) || (state_q == PAYLOAD) || (state_q == CHECK);
    assign done              = done_q;
    assign error             = error_q;

endmodule
